// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master engine: runs one command at a time (SINGLE, INCR, WRAPx, INCRx),
// pipelines address/data phases, stalls on hr_readyout and issues BUSY while write data is late.
module ahb_burst_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_LEN = 16,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_burst,
  input  logic [2:0]        cmd_size,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ready,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  input  logic              hr_readyout,
  input  logic [DATA_W-1:0] hr_data,
  output logic [ADDR_W-1:0] haddr,
  output logic [DATA_W-1:0] hwdata,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [1:0]        htrans,
  output logic              hready_in
);
  localparam int         CNT_W    = $clog2(((MAX_LEN > 16) ? MAX_LEN : 16) + 1);
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));
  localparam logic [1:0] HT_IDLE = 2'd0, HT_BUSY = 2'd1, HT_NONSEQ = 2'd2, HT_SEQ = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_BURST, S_LAST} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0] haddr_q;
  logic [DATA_W-1:0] hwdata_q, rdata_q;
  logic              hwrite_q, nseq_q, dph_q, rdata_valid_q, done_q;
  logic [2:0]        hsize_q, hburst_q;
  logic [CNT_W-1:0]  beats_q;

  logic              cmd_fire, beat_avail, beat_acc, dph_done, is_wrap, kb_cross;
  logic [2:0]        size_eff, wrap_shift;
  logic [CNT_W-1:0]  beats_eff;
  logic [ADDR_W-1:0] incr, addr_inc, wrap_mask, addr_next;
  logic [1:0]        htrans_c;

  assign cmd_fire   = cmd_valid & cmd_ready;
  assign beat_avail = ~hwrite_q | wdata_valid;
  assign beat_acc   = ((state_q == S_ADDR) || (state_q == S_BURST)) && beat_avail && hr_readyout;
  assign dph_done   = dph_q & hr_readyout;
  assign size_eff   = (cmd_size > MAX_SIZE) ? MAX_SIZE : cmd_size;

  always_comb begin
    beats_eff = CNT_W'(1);
    case (cmd_burst)
      3'd1:       beats_eff = (cmd_len == '0) ? CNT_W'(1) : CNT_W'(cmd_len);
      3'd2, 3'd3: beats_eff = CNT_W'(4);
      3'd4, 3'd5: beats_eff = CNT_W'(8);
      3'd6, 3'd7: beats_eff = CNT_W'(16);
      default:    beats_eff = CNT_W'(1);
    endcase
  end

  // Wrapping bursts keep the bits above the beats*incr window; incrementing ones flag 1KB crossings.
  assign incr       = ADDR_W'(1) << hsize_q;
  assign addr_inc   = haddr_q + incr;
  assign is_wrap    = (hburst_q == 3'd2) || (hburst_q == 3'd4) || (hburst_q == 3'd6);
  assign wrap_shift = (hburst_q == 3'd2) ? 3'd2 : ((hburst_q == 3'd4) ? 3'd3 : 3'd4);
  assign wrap_mask  = (incr << wrap_shift) - ADDR_W'(1);
  assign addr_next  = is_wrap ? ((haddr_q & ~wrap_mask) | (addr_inc & wrap_mask)) : addr_inc;
  assign kb_cross   = ~is_wrap && (addr_inc[9:0] == 10'd0);

  always_ff @(posedge hclk) begin
    if (hreset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_fire) state_d = S_ADDR;
      S_ADDR:  if (beat_acc) state_d = (beats_q == CNT_W'(1)) ? S_LAST : S_BURST;
      S_BURST: if (beat_acc && (beats_q == CNT_W'(1))) state_d = S_LAST;
      S_LAST:  if (dph_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A beat at a 1KB boundary restarts as NONSEQ, so a late-data gap there shows IDLE, not BUSY.
  always_comb begin
    htrans_c = HT_IDLE;
    case (state_q)
      S_ADDR:  htrans_c = beat_avail ? HT_NONSEQ : HT_IDLE;
      S_BURST: begin
        if (beat_avail) htrans_c = nseq_q ? HT_NONSEQ : HT_SEQ;
        else            htrans_c = nseq_q ? HT_IDLE : HT_BUSY;
      end
      default: htrans_c = HT_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      haddr_q       <= '0;
      hwdata_q      <= '0;
      hwrite_q      <= 1'b0;
      hsize_q       <= 3'd0;
      hburst_q      <= 3'd0;
      beats_q       <= '0;
      nseq_q        <= 1'b0;
      dph_q         <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q        <= (state_q == S_LAST) && dph_done;
      rdata_valid_q <= dph_done & ~hwrite_q;
      if (dph_done && !hwrite_q) rdata_q <= hr_data;
      if (beat_acc)         dph_q <= 1'b1;
      else if (hr_readyout) dph_q <= 1'b0;
      if (cmd_fire) begin
        haddr_q  <= cmd_addr;
        hwrite_q <= cmd_write;
        hsize_q  <= size_eff;
        hburst_q <= cmd_burst;
        beats_q  <= beats_eff;
        nseq_q   <= 1'b0;
      end else if (beat_acc) begin
        haddr_q <= addr_next;
        beats_q <= beats_q - CNT_W'(1);
        nseq_q  <= kb_cross;
        if (hwrite_q) hwdata_q <= wdata;
      end
    end
  end

  assign cmd_ready   = (state_q == S_IDLE) && !done_q;
  assign wdata_ready = hwrite_q & beat_acc;
  assign htrans      = htrans_c;
  assign haddr       = haddr_q;
  assign hwdata      = hwdata_q;
  assign hwrite      = hwrite_q;
  assign hsize       = hsize_q;
  assign hburst      = hburst_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign done        = done_q;
  assign hready_in   = hr_readyout;
endmodule

// File: tb/tb_ahb_burst_master.sv
// Scoreboard bench for ahb_burst_master: address/data/read beats predicted from burst arithmetic,
// checked by a negedge monitor; directed cases followed by randomized commands and slave timing.
module tb_ahb_burst_master;
  localparam int AW = 32, DW = 32, ML = 16, LW = $clog2(ML + 1);

  logic hclk = 1'b0, hreset = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [2:0] cmd_burst = '0, cmd_size = '0;
  logic [LW-1:0] cmd_len = '0;
  logic wdata_valid = 1'b0, wdata_ready;
  logic [DW-1:0] wdata = '0, rdata, hr_data = '0, hwdata;
  logic rdata_valid, done, hr_readyout = 1'b1, hwrite, hready_in;
  logic [AW-1:0] haddr;
  logic [2:0] hsize, hburst;
  logic [1:0] htrans;

  always #5 hclk = ~hclk;

  ahb_burst_master #(.ADDR_W(AW), .DATA_W(DW), .MAX_LEN(ML)) dut (
    .hclk(hclk), .hreset(hreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_size(cmd_size),
    .cmd_len(cmd_len), .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .hr_readyout(hr_readyout),
    .hr_data(hr_data), .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .htrans(htrans), .hready_in(hready_in));

  typedef struct {
    logic [31:0] addr;
    bit          ns;
    logic [2:0]  burst;
    logic [2:0]  size;
    bit          wr;
  } beat_t;

  beat_t       exp_beats[$];
  logic [31:0] exp_wd[$], exp_rd[$], wq[$];
  beat_t       mon_e;

  int pass_cnt = 0, chk_cnt = 0;
  int cyc = 0, acc_cyc = 0, done_cyc = 0, last_data_cyc = -10, done_cnt = 0, busy_cnt = 0;
  bit dph = 0, dph_wr = 0, wd_fired = 0, prev_stall = 0;
  logic [31:0] prev_addr = '0;
  logic [1:0]  prev_trans = '0;
  int rdy_pct = 100, wv_pct = 100, gap_at = -1, gap_left = 0, stall_at = -1, stall_left = 0;
  bit rd_fix = 0;
  logic [31:0] rd_val = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
  endtask

  // Monitor / scoreboard
  always @(negedge hclk) begin
    cyc++;
    if (hreset) begin
      dph = 0; prev_stall = 0; wd_fired = 0;
    end else begin
      wd_fired = wdata_valid & wdata_ready;
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (htrans == 2'd1) busy_cnt++;
      if (prev_stall) begin
        chk("stall_hold_haddr", haddr, prev_addr);
        chk("stall_hold_htrans", htrans, prev_trans);
      end
      if (rdata_valid) begin
        chk("rdata_expected", exp_rd.size() > 0, 1);
        if (exp_rd.size() > 0) chk("rdata", rdata, exp_rd.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_items_left", exp_beats.size() + exp_wd.size() + exp_rd.size(), 0);
        chk("done_after_last_data", cyc - last_data_cyc, 1);
        chk("cmd_ready_during_done", cmd_ready, 0);
      end
      if (dph && hr_readyout) begin
        last_data_cyc = cyc;
        if (dph_wr) begin
          chk("hwdata_expected", exp_wd.size() > 0, 1);
          if (exp_wd.size() > 0) chk("hwdata", hwdata, exp_wd.pop_front());
        end else exp_rd.push_back(hr_data);
      end
      if (htrans[1] && hr_readyout) begin
        chk("beat_expected", exp_beats.size() > 0, 1);
        if (exp_beats.size() > 0) begin
          mon_e = exp_beats.pop_front();
          chk("haddr", haddr, mon_e.addr);
          chk("htrans", htrans, mon_e.ns ? 2'd2 : 2'd3);
          chk("hwrite_hburst_hsize", {hwrite, hburst, hsize}, {mon_e.wr, mon_e.burst, mon_e.size});
        end
      end
      if (hr_readyout) begin
        dph = htrans[1];
        dph_wr = hwrite;
      end
      prev_stall = htrans[1] && !hr_readyout;
      prev_addr = haddr;
      prev_trans = htrans;
    end
  end

  // Write-data source and slave model
  initial begin
    forever begin
      @(posedge hclk); #1;
      if (hreset) begin
        wdata_valid = 0; hr_readyout = 1;
      end else begin
        if (wd_fired) wdata_valid = 0;
        if (!wdata_valid && wq.size() > 0) begin
          if (gap_at == wq.size() && gap_left > 0) gap_left--;
          else if ($urandom_range(99) < wv_pct) begin
            wdata = wq.pop_front(); wdata_valid = 1;
          end
        end
        if (stall_at == wq.size() && stall_left > 0) begin
          hr_readyout = 0; stall_left--;
        end else hr_readyout = ($urandom_range(99) < rdy_pct);
        hr_data = rd_fix ? rd_val : $urandom;
      end
    end
  end

  // Reference model: beat list from burst arithmetic, then command handshake.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [2:0] b,
                       input logic [2:0] sz, input int len, input logic [31:0] d0,
                       input bit use_d0, output int nb);
    int bytes, span, k;
    bit ok;
    logic [31:0] base, ad, d;
    logic [2:0] es;
    beat_t e;
    es = (sz > 3'd2) ? 3'd2 : sz;
    bytes = 1 << es;
    if (b == 3'd0) nb = 1;
    else if (b == 3'd1) nb = (len == 0) ? 1 : len;
    else nb = 4 << ((int'(b) - 2) / 2);
    span = nb * bytes;
    base = a - (a % span);
    for (int i = 0; i < nb; i++) begin
      if (b == 3'd2 || b == 3'd4 || b == 3'd6) begin
        ad = base + ((a - base + i * bytes) % span);
        e.ns = (i == 0);
      end else begin
        ad = a + i * bytes;
        e.ns = (i == 0) || (ad % 1024 == 0);
      end
      e.addr = ad; e.burst = b; e.size = es; e.wr = wr;
      exp_beats.push_back(e);
      if (wr) begin
        d = (i == 0 && use_d0) ? d0 : $urandom;
        exp_wd.push_back(d);
        wq.push_back(d);
      end
    end
    @(posedge hclk); #1;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_burst = b; cmd_size = sz; cmd_len = LW'(len);
    ok = 0; k = 0;
    while (!ok && k < 200) begin
      @(negedge hclk);
      ok = cmd_ready;
      k++;
    end
    chk("cmd_accepted", ok, 1);
    @(posedge hclk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_done(output bit ok);
    int start, k;
    start = done_cnt; k = 0;
    while (done_cnt == start && k < 3000) begin
      @(posedge hclk);
      k++;
    end
    ok = (done_cnt != start);
    chk("done_seen", ok, 1);
    @(posedge hclk); #1;
  endtask

  task automatic do_reset();
    @(posedge hclk); #1;
    hreset = 1; cmd_valid = 0;
    exp_beats.delete(); exp_wd.delete(); exp_rd.delete(); wq.delete();
    wdata_valid = 0;
    repeat (2) @(posedge hclk);
    #1 hreset = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, b0, d0;
    bit ok;
    logic [31:0] a;
    logic [2:0] sz, es, bb;

    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("rst_htrans", htrans, 0);
    chk("rst_haddr", haddr, 0);
    chk("rst_hwdata", hwdata, 0);
    chk("rst_hwrite_hsize_hburst", {hwrite, hsize, hburst}, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_done", done, 0);
    hr_readyout = 0;
    #1 chk("hready_in_low", hready_in, 0);
    hr_readyout = 1;
    #1 chk("hready_in_high", hready_in, 1);
    @(posedge hclk); #1 hreset = 0;

    // Directed cases with an always-ready slave and prompt write data
    issue(1, 32'h8000_0000, 3'd0, 3'd0, 1, 32'h24, 1, nb);
    wait_done(ok);
    chk("lat_single_write", done_cyc - acc_cyc, nb + 2);

    rd_fix = 1; rd_val = 32'h55;
    issue(0, 32'h8000_0000, 3'd0, 3'd0, 1, 0, 0, nb);
    wait_done(ok);
    chk("lat_single_read", done_cyc - acc_cyc, nb + 2);
    rd_fix = 0;

    issue(1, 32'h8000_0000, 3'd3, 3'd0, 0, 0, 0, nb);
    wait_done(ok);
    chk("lat_incr4_write", done_cyc - acc_cyc, nb + 2);

    issue(0, 32'h8000_0038, 3'd2, 3'd2, 0, 0, 0, nb);
    wait_done(ok);
    chk("lat_wrap4_read", done_cyc - acc_cyc, nb + 2);

    issue(0, 32'h0000_03F8, 3'd1, 3'd2, 4, 0, 0, nb);
    wait_done(ok);
    chk("lat_incr_1kb", done_cyc - acc_cyc, nb + 2);

    gap_at = 4; gap_left = 2; stall_at = 2; stall_left = 2; b0 = busy_cnt;
    issue(1, 32'h8000_0100, 3'd5, 3'd2, 0, 0, 0, nb);
    wait_done(ok);
    chk("incr8_busy_cycles", busy_cnt - b0, 2);
    chk("lat_incr8_gap_stall", done_cyc - acc_cyc, nb + 6);
    gap_at = -1; stall_at = -1;

    issue(0, 32'h0000_0200, 3'd7, 3'd3, 0, 0, 0, nb);
    wait_done(ok);
    chk("lat_incr16_size_forced", done_cyc - acc_cyc, nb + 2);

    // Abort an INCR16 read part-way through
    issue(0, 32'h0000_1000, 3'd7, 3'd2, 0, 0, 0, nb);
    repeat (5) @(posedge hclk);
    #1 hreset = 1;
    exp_beats.delete(); exp_wd.delete(); exp_rd.delete(); wq.delete();
    @(posedge hclk);
    @(negedge hclk);
    chk("abort_htrans", htrans, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_rdata_valid", rdata_valid, 0);
    @(posedge hclk); #1 hreset = 0;
    d0 = done_cnt;
    repeat (10) @(posedge hclk);
    chk("abort_no_done", done_cnt - d0, 0);

    // Randomized commands with random wait states and write-data gaps
    rdy_pct = 75; wv_pct = 70;
    for (int n = 0; n < 40; n++) begin
      sz = 3'($urandom_range(3));
      es = (sz > 3'd2) ? 3'd2 : sz;
      bb = 3'($urandom_range(7));
      a = $urandom & ~((32'd1 << es) - 32'd1);
      if ($urandom_range(2) == 0) a[9:0] = 10'h3E0;
      issue(1'($urandom_range(1)), a, bb, sz, $urandom_range(ML), 0, 0, nb);
      wait_done(ok);
      if (!ok) do_reset();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
